// File: rtl/wb_select_unit.sv
// Registered writeback select: one of NUM_SRC sources or an aligned/extended load, 1 cycle after accept or load response.
// Backpressure: in_ready is low while a load response is outstanding (WAIT_MEM) or being drained after a flush (DRAIN).
module wb_select_unit #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 4,
  parameter int LOAD_SRC = 1,
  parameter int SEL_W    = $clog2(NUM_SRC),
  parameter int OFF_W    = $clog2(XLEN/8)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [4:0]              in_rd,
  input  logic                    in_rd_we,
  input  logic [2:0]              in_funct3,
  input  logic [OFF_W-1:0]        in_addr_lo,
  input  logic [NUM_SRC*XLEN-1:0] in_src_data,
  input  logic                    flush,
  input  logic [XLEN-1:0]         mem_rdata,
  input  logic                    mem_rvalid,
  output logic                    wb_valid,
  output logic                    wb_we,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_data,
  output logic                    wb_misalign
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

  typedef struct packed {
    logic [4:0]       rd;
    logic             rd_we;
    logic [2:0]       funct3;
    logic [OFF_W-1:0] addr_lo;
  } ld_t;

  state_t           state, state_nxt;
  ld_t              ld_q;
  logic             accept, is_load, sel_ok;
  logic [XLEN-1:0]  src_dat, lane, ext_dat;
  logic             ext_mis;
  logic [2:0]       cur_f3;
  logic [OFF_W-1:0] cur_off;
  logic             nxt_vld, nxt_we, nxt_mis;
  logic [4:0]       nxt_rd;
  logic [XLEN-1:0]  nxt_dat;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign is_load  = (in_sel == SEL_W'(LOAD_SRC));
  assign sel_ok   = (int'(in_sel) < NUM_SRC);

  // Out-of-range selects fall through to zero
  always_comb begin
    src_dat = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) src_dat = in_src_data[k*XLEN +: XLEN];
    end
  end

  // Extension decodes the held fields once a load is outstanding
  assign cur_f3  = (state == WAIT_MEM) ? ld_q.funct3  : in_funct3;
  assign cur_off = (state == WAIT_MEM) ? ld_q.addr_lo : in_addr_lo;
  assign lane    = mem_rdata >> {cur_off, 3'b000};

  always_comb begin
    ext_dat = '0;
    ext_mis = 1'b0;
    case (cur_f3)
      3'b000: ext_dat = XLEN'($signed(lane[7:0]));
      3'b100: ext_dat = XLEN'(lane[7:0]);
      3'b001: if (cur_off[0]) ext_mis = 1'b1; else ext_dat = XLEN'($signed(lane[15:0]));
      3'b101: if (cur_off[0]) ext_mis = 1'b1; else ext_dat = XLEN'(lane[15:0]);
      3'b010: if (cur_off[1:0] != 2'b00) ext_mis = 1'b1; else ext_dat = XLEN'($signed(lane[31:0]));
      3'b110: if (XLEN == 32 || cur_off[1:0] != 2'b00) ext_mis = 1'b1; else ext_dat = XLEN'(lane[31:0]);
      3'b011: if (XLEN == 64 && cur_off == '0) ext_dat = lane; else ext_mis = 1'b1;
      default: ext_mis = 1'b1;
    endcase
    if (ext_mis) ext_dat = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Flush beats a coincident response: nothing left to drain
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && is_load && !mem_rvalid) state_nxt = WAIT_MEM;
      WAIT_MEM: if (flush) state_nxt = mem_rvalid ? IDLE : DRAIN;
                else if (mem_rvalid) state_nxt = IDLE;
      DRAIN:    if (mem_rvalid) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    nxt_vld = 1'b0;
    nxt_we  = 1'b0;
    nxt_mis = 1'b0;
    nxt_rd  = in_rd;
    nxt_dat = '0;
    case (state)
      IDLE: begin
        if (accept && !is_load) begin
          nxt_vld = 1'b1;
          nxt_dat = src_dat;
          nxt_we  = in_rd_we && (in_rd != 5'd0) && sel_ok;
        end else if (accept && mem_rvalid) begin
          nxt_vld = 1'b1;
          nxt_mis = ext_mis;
          nxt_dat = ext_dat;
          nxt_we  = in_rd_we && (in_rd != 5'd0) && !ext_mis;
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid && !flush) begin
          nxt_vld = 1'b1;
          nxt_rd  = ld_q.rd;
          nxt_mis = ext_mis;
          nxt_dat = ext_dat;
          nxt_we  = ld_q.rd_we && (ld_q.rd != 5'd0) && !ext_mis;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q <= '0;
    end else if (accept && is_load && !mem_rvalid) begin
      ld_q <= '{rd: in_rd, rd_we: in_rd_we, funct3: in_funct3, addr_lo: in_addr_lo};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_misalign <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= '0;
    end else begin
      wb_valid    <= nxt_vld;
      wb_we       <= nxt_we;
      wb_misalign <= nxt_mis;
      if (nxt_vld) begin
        wb_rd   <= nxt_rd;
        wb_data <= nxt_dat;
      end
    end
  end

endmodule

// File: tb/tb_wb_select_unit.sv
// Bench for wb_select_unit: a 32-bit/4-source instance and a 64-bit/5-source instance on one clock.
module tb_wb_select_unit;

  typedef struct {
    logic        inst;
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic        rd_we;
    logic [2:0]  f3;
    logic [2:0]  off;
    logic        rvalid;
    logic [63:0] rdata;
    logic        exp_we;
    logic [63:0] exp_data;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         a_in_valid, a_in_ready, a_in_rd_we, a_flush, a_mem_rvalid;
  logic [1:0]   a_in_sel, a_in_addr_lo;
  logic [4:0]   a_in_rd, a_wb_rd;
  logic [2:0]   a_in_funct3;
  logic [127:0] a_src;
  logic [31:0]  a_mem_rdata, a_wb_data;
  logic         a_wb_valid, a_wb_we, a_wb_misalign;

  logic         b_in_valid, b_in_ready, b_in_rd_we, b_flush, b_mem_rvalid;
  logic [2:0]   b_in_sel, b_in_addr_lo;
  logic [4:0]   b_in_rd, b_wb_rd;
  logic [2:0]   b_in_funct3;
  logic [319:0] b_src;
  logic [63:0]  b_mem_rdata, b_wb_data;
  logic         b_wb_valid, b_wb_we, b_wb_misalign;

  wb_select_unit #(.XLEN(32), .NUM_SRC(4), .LOAD_SRC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_sel(a_in_sel), .in_rd(a_in_rd), .in_rd_we(a_in_rd_we), .in_funct3(a_in_funct3),
    .in_addr_lo(a_in_addr_lo), .in_src_data(a_src), .flush(a_flush),
    .mem_rdata(a_mem_rdata), .mem_rvalid(a_mem_rvalid), .wb_valid(a_wb_valid),
    .wb_we(a_wb_we), .wb_rd(a_wb_rd), .wb_data(a_wb_data), .wb_misalign(a_wb_misalign)
  );

  wb_select_unit #(.XLEN(64), .NUM_SRC(5), .LOAD_SRC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sel(b_in_sel), .in_rd(b_in_rd), .in_rd_we(b_in_rd_we), .in_funct3(b_in_funct3),
    .in_addr_lo(b_in_addr_lo), .in_src_data(b_src), .flush(b_flush),
    .mem_rdata(b_mem_rdata), .mem_rvalid(b_mem_rvalid), .wb_valid(b_wb_valid),
    .wb_we(b_wb_we), .wb_rd(b_wb_rd), .wb_data(b_wb_data), .wb_misalign(b_wb_misalign)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  vec_t tbl[29];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_flush = 1'b0; a_mem_rvalid = 1'b0;
    b_in_valid = 1'b0; b_flush = 1'b0; b_mem_rvalid = 1'b0;
  endtask

  task automatic push_a(input logic we, input logic [4:0] rd, input logic [63:0] d, input logic mis);
    exp_t e;
    e.we = we; e.rd = rd; e.data = d; e.mis = mis;
    qa.push_back(e);
  endtask

  task automatic drive_vec(input vec_t v);
    exp_t e;
    idle_inputs();
    e.we = v.exp_we; e.rd = v.rd; e.data = v.exp_data; e.mis = v.exp_mis;
    if (!v.inst) begin
      a_in_valid = 1'b1; a_in_sel = v.sel[1:0]; a_in_rd = v.rd; a_in_rd_we = v.rd_we;
      a_in_funct3 = v.f3; a_in_addr_lo = v.off[1:0];
      a_mem_rvalid = v.rvalid; a_mem_rdata = v.rdata[31:0];
      qa.push_back(e);
    end else begin
      b_in_valid = 1'b1; b_in_sel = v.sel; b_in_rd = v.rd; b_in_rd_we = v.rd_we;
      b_in_funct3 = v.f3; b_in_addr_lo = v.off;
      b_mem_rvalid = v.rvalid; b_mem_rdata = v.rdata;
      qb.push_back(e);
    end
  endtask

  // Load on instance A whose response arrives nwait cycles after acceptance
  task automatic a_load_wait(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                             input logic [31:0] rdata, input int nwait, input logic [63:0] exp);
    idle_inputs();
    a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_rd = rd; a_in_rd_we = 1'b1;
    a_in_funct3 = f3; a_in_addr_lo = off;
    cyc();
    a_in_valid = 1'b0;
    for (int i = 1; i <= nwait; i++) begin
      chk("a_ready_wait", 64'(a_in_ready), 64'd0);
      if (i == nwait) begin
        a_mem_rvalid = 1'b1; a_mem_rdata = rdata;
        push_a(1'b1, rd, exp, 1'b0);
      end
      cyc();
    end
    a_mem_rvalid = 1'b0;
    chk("a_ready_after_resp", 64'(a_in_ready), 64'd1);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_wb_valid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_wb: got wb_valid=1 rd=%0d data=%h, expected no writeback (t=%0t)", a_wb_rd, a_wb_data, $time);
      end else begin
        e = qa.pop_front();
        chk("a_wb_we", 64'(a_wb_we), 64'(e.we));
        chk("a_wb_rd", 64'(a_wb_rd), 64'(e.rd));
        chk("a_wb_data", {32'h0, a_wb_data}, e.data);
        chk("a_wb_misalign", 64'(a_wb_misalign), 64'(e.mis));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_wb_valid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_wb: got wb_valid=1 rd=%0d data=%h, expected no writeback (t=%0t)", b_wb_rd, b_wb_data, $time);
      end else begin
        e = qb.pop_front();
        chk("b_wb_we", 64'(b_wb_we), 64'(e.we));
        chk("b_wb_rd", 64'(b_wb_rd), 64'(e.rd));
        chk("b_wb_data", b_wb_data, e.data);
        chk("b_wb_misalign", 64'(b_wb_misalign), 64'(e.mis));
      end
    end
  end

  initial begin
    // {inst, sel, rd, rd_we, f3, off, rvalid, rdata, exp_we, exp_data, exp_mis}
    tbl[0]  = '{1'b0, 3'd0, 5'd5,  1'b1, 3'b000, 3'd0, 1'b0, 64'h0, 1'b1, 64'h0000_1234, 1'b0};
    tbl[1]  = '{1'b0, 3'd2, 5'd6,  1'b1, 3'b000, 3'd0, 1'b0, 64'h0, 1'b1, 64'hA5A5_0002, 1'b0};
    tbl[2]  = '{1'b0, 3'd3, 5'd0,  1'b1, 3'b000, 3'd0, 1'b0, 64'h0, 1'b0, 64'h8000_0003, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 5'd7,  1'b0, 3'b000, 3'd0, 1'b0, 64'h0, 1'b0, 64'h0000_1234, 1'b0};
    tbl[4]  = '{1'b0, 3'd1, 5'd8,  1'b1, 3'b000, 3'd2, 1'b1, 64'h0080_0000, 1'b1, 64'hFFFF_FF80, 1'b0};
    tbl[5]  = '{1'b0, 3'd1, 5'd8,  1'b1, 3'b100, 3'd2, 1'b1, 64'h0080_0000, 1'b1, 64'h0000_0080, 1'b0};
    tbl[6]  = '{1'b0, 3'd1, 5'd9,  1'b1, 3'b001, 3'd1, 1'b1, 64'h0080_0000, 1'b0, 64'h0, 1'b1};
    tbl[7]  = '{1'b0, 3'd1, 5'd10, 1'b1, 3'b101, 3'd2, 1'b1, 64'h8001_0000, 1'b1, 64'h0000_8001, 1'b0};
    tbl[8]  = '{1'b0, 3'd1, 5'd10, 1'b1, 3'b001, 3'd2, 1'b1, 64'h8001_0000, 1'b1, 64'hFFFF_8001, 1'b0};
    tbl[9]  = '{1'b0, 3'd1, 5'd11, 1'b1, 3'b010, 3'd0, 1'b1, 64'h1234_5678, 1'b1, 64'h1234_5678, 1'b0};
    tbl[10] = '{1'b0, 3'd1, 5'd11, 1'b1, 3'b110, 3'd0, 1'b1, 64'h1234_5678, 1'b0, 64'h0, 1'b1};
    tbl[11] = '{1'b0, 3'd1, 5'd11, 1'b1, 3'b011, 3'd0, 1'b1, 64'h1234_5678, 1'b0, 64'h0, 1'b1};
    tbl[12] = '{1'b0, 3'd1, 5'd11, 1'b1, 3'b111, 3'd0, 1'b1, 64'h1234_5678, 1'b0, 64'h0, 1'b1};
    tbl[13] = '{1'b0, 3'd1, 5'd11, 1'b1, 3'b010, 3'd2, 1'b1, 64'h1234_5678, 1'b0, 64'h0, 1'b1};
    tbl[14] = '{1'b0, 3'd1, 5'd12, 1'b1, 3'b000, 3'd3, 1'b1, 64'h7F00_0000, 1'b1, 64'h0000_007F, 1'b0};
    tbl[15] = '{1'b0, 3'd1, 5'd0,  1'b1, 3'b100, 3'd0, 1'b1, 64'h0000_00FF, 1'b0, 64'h0000_00FF, 1'b0};
    tbl[16] = '{1'b1, 3'd0, 5'd1,  1'b1, 3'b000, 3'd0, 1'b0, 64'h0, 1'b1, 64'h1111_2222_3333_4444, 1'b0};
    tbl[17] = '{1'b1, 3'd4, 5'd2,  1'b1, 3'b000, 3'd0, 1'b0, 64'h0, 1'b1, 64'h4444_0000_0000_0004, 1'b0};
    tbl[18] = '{1'b1, 3'd5, 5'd3,  1'b1, 3'b000, 3'd0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
    tbl[19] = '{1'b1, 3'd7, 5'd3,  1'b1, 3'b000, 3'd0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0};
    tbl[20] = '{1'b1, 3'd1, 5'd4,  1'b1, 3'b011, 3'd0, 1'b1, 64'h8000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0001, 1'b0};
    tbl[21] = '{1'b1, 3'd1, 5'd4,  1'b1, 3'b011, 3'd4, 1'b1, 64'h8000_0000_0000_0001, 1'b0, 64'h0, 1'b1};
    tbl[22] = '{1'b1, 3'd1, 5'd5,  1'b1, 3'b010, 3'd4, 1'b1, 64'h8765_4321_0000_0000, 1'b1, 64'hFFFF_FFFF_8765_4321, 1'b0};
    tbl[23] = '{1'b1, 3'd1, 5'd5,  1'b1, 3'b110, 3'd4, 1'b1, 64'h8765_4321_0000_0000, 1'b1, 64'h0000_0000_8765_4321, 1'b0};
    tbl[24] = '{1'b1, 3'd1, 5'd6,  1'b1, 3'b000, 3'd7, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    tbl[25] = '{1'b1, 3'd1, 5'd6,  1'b1, 3'b001, 3'd6, 1'b1, 64'h7FFF_0000_0000_0000, 1'b1, 64'h0000_0000_0000_7FFF, 1'b0};
    tbl[26] = '{1'b1, 3'd1, 5'd7,  1'b1, 3'b111, 3'd0, 1'b1, 64'h7FFF_0000_0000_0000, 1'b0, 64'h0, 1'b1};
    tbl[27] = '{1'b1, 3'd1, 5'd7,  1'b1, 3'b010, 3'd2, 1'b1, 64'h7FFF_0000_0000_0000, 1'b0, 64'h0, 1'b1};
    tbl[28] = '{1'b1, 3'd2, 5'd31, 1'b1, 3'b000, 3'd0, 1'b0, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};

    a_src = {32'h8000_0003, 32'hA5A5_0002, 32'hDEAD_BEEF, 32'h0000_1234};
    b_src = {64'h4444_0000_0000_0004, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF,
             64'hDEAD_BEEF_DEAD_BEEF, 64'h1111_2222_3333_4444};
    a_in_sel = '0; a_in_rd = '0; a_in_rd_we = 1'b0; a_in_funct3 = '0; a_in_addr_lo = '0; a_mem_rdata = '0;
    b_in_sel = '0; b_in_rd = '0; b_in_rd_we = 1'b0; b_in_funct3 = '0; b_in_addr_lo = '0; b_mem_rdata = '0;
    idle_inputs();

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_reset_ready", 64'(a_in_ready), 64'd1);
    chk("a_reset_valid", 64'(a_wb_valid), 64'd0);
    chk("a_reset_we", 64'(a_wb_we), 64'd0);
    chk("a_reset_mis", 64'(a_wb_misalign), 64'd0);
    chk("a_reset_rd", 64'(a_wb_rd), 64'd0);
    chk("a_reset_data", 64'(a_wb_data), 64'd0);
    chk("b_reset_data", b_wb_data, 64'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc();
      drive_vec(tbl[i]);
    end
    cyc();
    idle_inputs();

    a_load_wait(3'b000, 2'd2, 5'd11, 32'h0080_0000, 3, 64'hFFFF_FF80);
    a_load_wait(3'b100, 2'd2, 5'd12, 32'h0080_0000, 3, 64'h0000_0080);

    // Flushed load: response drained without a writeback, then an ALU op
    a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_rd = 5'd13; a_in_funct3 = 3'b010; a_in_addr_lo = 2'd0;
    cyc();
    a_in_valid = 1'b0; a_flush = 1'b1;
    cyc();
    chk("a_ready_drain1", 64'(a_in_ready), 64'd0);
    cyc();
    a_flush = 1'b0;
    chk("a_ready_drain2", 64'(a_in_ready), 64'd0);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h5555_5555;
    cyc();
    a_mem_rvalid = 1'b0;
    chk("a_ready_after_drain", 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_rd = 5'd3; a_in_rd_we = 1'b1;
    push_a(1'b1, 5'd3, 64'hA5A5_0002, 1'b0);
    cyc();
    a_in_valid = 1'b0;

    // Flush and response together while waiting
    a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_rd = 5'd14; a_in_funct3 = 3'b000;
    cyc();
    a_in_valid = 1'b0; a_flush = 1'b1; a_mem_rvalid = 1'b1;
    cyc();
    a_flush = 1'b0; a_mem_rvalid = 1'b0;
    chk("a_ready_flush_rvalid", 64'(a_in_ready), 64'd1);

    // Flush in IDLE blocks acceptance; stray response in IDLE ignored
    a_in_valid = 1'b1; a_in_sel = 2'd0; a_in_rd = 5'd15; a_flush = 1'b1;
    cyc();
    a_in_valid = 1'b0; a_flush = 1'b0; a_mem_rvalid = 1'b1;
    cyc();
    a_mem_rvalid = 1'b0;
    chk("a_ready_idle", 64'(a_in_ready), 64'd1);

    // Flush after a pulse is registered must not kill it
    a_in_valid = 1'b1; a_in_sel = 2'd3; a_in_rd = 5'd4; a_in_rd_we = 1'b1;
    push_a(1'b1, 5'd4, 64'h8000_0003, 1'b0);
    cyc();
    a_in_valid = 1'b0; a_flush = 1'b1;
    cyc();
    a_flush = 1'b0;

    // Reset during WAIT_MEM on the 64-bit instance; late response ignored
    b_in_valid = 1'b1; b_in_sel = 3'd1; b_in_rd = 5'd20; b_in_rd_we = 1'b1;
    b_in_funct3 = 3'b011; b_in_addr_lo = 3'd0;
    cyc();
    b_in_valid = 1'b0;
    chk("b_ready_wait", 64'(b_in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("b_ready_in_reset", 64'(b_in_ready), 64'd1);
    chk("b_valid_in_reset", 64'(b_wb_valid), 64'd0);
    chk("b_data_in_reset", b_wb_data, 64'd0);
    chk("a_data_in_reset", 64'(a_wb_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    b_mem_rvalid = 1'b1; b_mem_rdata = 64'h8000_0000_0000_0001;
    cyc();
    b_mem_rvalid = 1'b0;
    chk("b_ready_after_reset", 64'(b_in_ready), 64'd1);

    repeat (3) cyc();
    chk("a_queue_empty", 64'(qa.size()), 64'd0);
    chk("b_queue_empty", 64'(qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
